gesture_frame_ctrl: RTL and testbench
=====================================

Name: gesture_frame_ctrl

Overview:
- Frame-level sequencer for the binary-image gesture detector.
- Tracks frame boundaries from vsync, drives the detector's ROI window and a per-frame start pulse, captures the per-frame bbox/area/fingertip ratio on the detector's done level, classifies it, and debounces across frames.
- Sits between the detector and the display/UART consumer. Emits one gesture_valid pulse per stable gesture change.

Parameters:
- ROI_X0, 150, default ROI left column.
- ROI_X1, 450, default ROI right column.
- ROI_Y0, 50, default ROI top row.
- ROI_Y1, 350, default ROI bottom row.
- MIN_AREA, 400, bbox area below this classifies as NONE.
- THR_FIST, 20, ratio below this classifies as FIST.
- THR_OPEN, 40, ratio below this (and >= THR_FIST) classifies as POINT; otherwise OPEN.
- STABLE_FRAMES, 3, consecutive identical classifications required to report (1..15).
- TIMEOUT_FRAMES, 4, vsync edges in MEASURE without a result before timeout (1..15).
- ROI_MARGIN, 16, bbox expansion used only with the optional feature.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  run control; 0 forces IDLE.
- per_frame_vsync  in  1  frame sync from the preprocessing chain.
- det_en  in  1  detector result-valid level (rises at end of ROI, falls at next frame start).
- det_x_min, det_x_max, det_y_min, det_y_max  in  12 each  detector bbox.
- det_area  in  20  bbox area.
- det_ratio  in  20  fingertip ratio (area/length).
- roi_x0, roi_x1, roi_y0, roi_y1  out  12 each  ROI configuration to the detector.
- det_start  out  1  one-cycle pulse at each accepted frame start.
- gesture_code  out  2  0=NONE, 1=FIST, 2=POINT, 3=OPEN.
- gesture_valid  out  1  one-cycle pulse when gesture_code changes.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky; cleared only by reset or enable low.

Behaviour:
- Reset values:
  - roi_* = ROI_X0/ROI_X1/ROI_Y0/ROI_Y1.
  - gesture_code=0, gesture_valid=0, det_start=0, busy=0, timeout_err=0.
  - Candidate code=0, stable count=0, state=IDLE.
- Edge detection: vsync_rise = vsync & ~vsync_d1. det_rise = det_en & ~det_en_d1. Both registered, so detection lags the input by one cycle.
- IDLE: when enable=1, go to ARM.
- ARM: on vsync_rise, pulse det_start for 1 cycle, clear the timeout counter, go to MEASURE.
- MEASURE:
  - On det_rise, latch all det_* inputs and go to CLASSIFY.
  - On vsync_rise, increment the timeout counter and pulse det_start.
  - When the counter reaches TIMEOUT_FRAMES: set timeout_err, clear candidate and stable count, go to ARM.
  - If det_rise and vsync_rise occur in the same cycle, det_rise wins and the timeout counter is not incremented.
- CLASSIFY (exactly 1 cycle):
  - code = NONE if area<MIN_AREA; else FIST if ratio<THR_FIST; else POINT if ratio<THR_OPEN; else OPEN.
  - All comparisons are unsigned and 20-bit.
  - If code == candidate, stable count increments, saturating at 15. Otherwise candidate=code and count=1.
  - Go to REPORT.
- REPORT (1 cycle):
  - If count == STABLE_FRAMES and candidate != gesture_code: update gesture_code and pulse gesture_valid in the same cycle.
  - Go to ARM.
  - Latency from det_rise to gesture_valid is 3 clk cycles.
- gesture_valid never fires twice for the same code; a repeated stable gesture stays silent.
- enable=0 in any state: go to IDLE next cycle, clear timeout_err, candidate, count, and the pending det_start. gesture_code holds its value.
- Reset mid-frame: all state returns to reset values immediately. The first frame after reset is lost, because ARM needs a fresh vsync_rise.

Optional Feature:
- Macro: GESTURE_AUTO_ROI_EN.
- Defined: in REPORT, when latched area >= MIN_AREA, set the next ROI to bbox ± ROI_MARGIN, clamped to [ROI_X0,ROI_X1]×[ROI_Y0,ROI_Y1].
  - Clamp arithmetic uses 13-bit signed values so that subtraction cannot underflow.
  - A NONE result or a timeout restores the default ROI.
  - roi_* change only in REPORT or on timeout, never within MEASURE.
- Undefined: roi_* are constant at parameter values.

Test Plan:
- Reset then enable=1, vsync pulses → busy=1, det_start pulses once per vsync, roi_*=150/450/50/350, gesture_valid stays 0.
- Three frames with area=5000, ratio=50 → gesture_valid pulses exactly once, 3 clk after the third det_rise, with gesture_code=3. A fourth identical frame gives no pulse.
- Frames with ratios 10, 10, 30, 10, 10, 10 (area 5000) → a single pulse after the sixth frame, code=1. The alternating candidate resets the count.
- Area=300, ratio=10 for 3 frames after OPEN was reported → pulse with code=0.
- No det_en for 4 vsync edges → timeout_err=1, state returns to ARM. Setting enable=0 for 1 cycle clears timeout_err; gesture_code is unchanged.
- With GESTURE_AUTO_ROI_EN defined, bbox 160..200 × 60..100 → next ROI is 150/216/50/116. A following NONE frame restores 150/450/50/350.

Source files
------------

// File: rtl/gesture_frame_ctrl.sv
// rtl/gesture_frame_ctrl.sv - frame sequencer, classifier and debouncer for the gesture detector
//
// Purpose: tracks frames from per_frame_vsync, pulses det_start at each accepted
// frame start, captures the detector result on the rising edge of det_en,
// classifies it into NONE/FIST/POINT/OPEN and reports a gesture only after
// STABLE_FRAMES identical consecutive classifications.
//
// Optional feature macro: GESTURE_AUTO_ROI_EN (ROI tracks bbox +/- ROI_MARGIN).
//
// Ports:
//   clk, rst_n                  pixel clock, asynchronous active-low reset
//   enable                      run control, low forces IDLE
//   per_frame_vsync             frame sync
//   det_en                      detector result-valid level
//   det_x/y_min/max, det_area,
//   det_ratio                   detector result
//   roi_x0/x1/y0/y1             ROI window to the detector
//   det_start                   one-cycle pulse per accepted frame start
//   gesture_code, gesture_valid reported gesture and its change pulse
//   busy                        high outside IDLE
//   timeout_err                 sticky timeout flag, cleared by enable low

module gesture_frame_ctrl #(
  parameter int ROI_X0         = 150,
  parameter int ROI_X1         = 450,
  parameter int ROI_Y0         = 50,
  parameter int ROI_Y1         = 350,
  parameter int MIN_AREA       = 400,
  parameter int THR_FIST       = 20,
  parameter int THR_OPEN       = 40,
  parameter int STABLE_FRAMES  = 3,
  parameter int TIMEOUT_FRAMES = 4,
  parameter int ROI_MARGIN     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        per_frame_vsync,
  input  logic        det_en,
  input  logic [11:0] det_x_min,
  input  logic [11:0] det_x_max,
  input  logic [11:0] det_y_min,
  input  logic [11:0] det_y_max,
  input  logic [19:0] det_area,
  input  logic [19:0] det_ratio,
  output logic [11:0] roi_x0,
  output logic [11:0] roi_x1,
  output logic [11:0] roi_y0,
  output logic [11:0] roi_y1,
  output logic        det_start,
  output logic [1:0]  gesture_code,
  output logic        gesture_valid,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_MEASURE,
    S_CLASSIFY,
    S_REPORT
  } state_t;

  state_t      state, state_nxt;
  logic        vsync_d1, det_en_d1, vsync_rise, det_rise;
  logic [3:0]  tcnt;
  logic [3:0]  stable_cnt;
  logic [1:0]  cand_code;
  logic [1:0]  class_code;
  logic [19:0] lat_area, lat_ratio;
  logic        timeout_hit;

  // Edge detectors are registered, so events lag the inputs by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d1   <= 1'b0;
      det_en_d1  <= 1'b0;
      vsync_rise <= 1'b0;
      det_rise   <= 1'b0;
    end else begin
      vsync_d1   <= per_frame_vsync;
      det_en_d1  <= det_en;
      vsync_rise <= per_frame_vsync & ~vsync_d1;
      det_rise   <= det_en & ~det_en_d1;
    end
  end

  // A result arriving together with a frame edge wins over the timeout count.
  assign timeout_hit = (state == S_MEASURE) && vsync_rise && !det_rise &&
                       (tcnt == 4'(TIMEOUT_FRAMES - 1));

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:     state_nxt = S_ARM;
        S_ARM:      if (vsync_rise) state_nxt = S_MEASURE;
        S_MEASURE:  if (det_rise) state_nxt = S_CLASSIFY;
                    else if (timeout_hit) state_nxt = S_ARM;
        S_CLASSIFY: state_nxt = S_REPORT;
        S_REPORT:   state_nxt = S_ARM;
        default:    state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    class_code = 2'd3;
    if (lat_area < 20'(MIN_AREA))       class_code = 2'd0;
    else if (lat_ratio < 20'(THR_FIST)) class_code = 2'd1;
    else if (lat_ratio < 20'(THR_OPEN)) class_code = 2'd2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt          <= 4'd0;
      stable_cnt    <= 4'd0;
      cand_code     <= 2'd0;
      gesture_code  <= 2'd0;
      gesture_valid <= 1'b0;
      det_start     <= 1'b0;
      timeout_err   <= 1'b0;
      lat_area      <= 20'd0;
      lat_ratio     <= 20'd0;
    end else begin
      det_start     <= 1'b0;
      gesture_valid <= 1'b0;
      if (!enable) begin
        tcnt        <= 4'd0;
        stable_cnt  <= 4'd0;
        cand_code   <= 2'd0;
        timeout_err <= 1'b0;
      end else begin
        case (state)
          S_ARM: begin
            if (vsync_rise) begin
              det_start <= 1'b1;
              tcnt      <= 4'd0;
            end
          end
          S_MEASURE: begin
            if (det_rise) begin
              lat_area  <= det_area;
              lat_ratio <= det_ratio;
            end else if (vsync_rise) begin
              det_start <= 1'b1;
              if (timeout_hit) begin
                tcnt        <= 4'd0;
                timeout_err <= 1'b1;
                cand_code   <= 2'd0;
                stable_cnt  <= 4'd0;
              end else begin
                tcnt <= tcnt + 4'd1;
              end
            end
          end
          S_CLASSIFY: begin
            if (class_code == cand_code) begin
              if (stable_cnt != 4'd15) stable_cnt <= stable_cnt + 4'd1;
            end else begin
              cand_code  <= class_code;
              stable_cnt <= 4'd1;
            end
          end
          S_REPORT: begin
            // Only a change of the reported code is announced.
            if (stable_cnt == 4'(STABLE_FRAMES) && cand_code != gesture_code) begin
              gesture_code  <= cand_code;
              gesture_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef GESTURE_AUTO_ROI_EN
  logic [11:0] lat_x_min, lat_x_max, lat_y_min, lat_y_max;

  // Expanded edge in 13-bit signed space so bbox - margin cannot wrap.
  function automatic logic [11:0] clamp_edge(input logic [11:0] edge_v, input logic grow,
                                             input int lo, input int hi);
    logic signed [12:0] v, lo_s, hi_s;
    lo_s = 13'(lo);
    hi_s = 13'(hi);
    if (grow) v = $signed({1'b0, edge_v}) + $signed(13'(ROI_MARGIN));
    else      v = $signed({1'b0, edge_v}) - $signed(13'(ROI_MARGIN));
    if (v < lo_s)      return 12'(lo);
    else if (v > hi_s) return 12'(hi);
    else               return v[11:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_x_min <= 12'd0;
      lat_x_max <= 12'd0;
      lat_y_min <= 12'd0;
      lat_y_max <= 12'd0;
      roi_x0    <= 12'(ROI_X0);
      roi_x1    <= 12'(ROI_X1);
      roi_y0    <= 12'(ROI_Y0);
      roi_y1    <= 12'(ROI_Y1);
    end else begin
      if (state == S_MEASURE && det_rise) begin
        lat_x_min <= det_x_min;
        lat_x_max <= det_x_max;
        lat_y_min <= det_y_min;
        lat_y_max <= det_y_max;
      end
      if (timeout_hit || (state == S_REPORT && lat_area < 20'(MIN_AREA))) begin
        roi_x0 <= 12'(ROI_X0);
        roi_x1 <= 12'(ROI_X1);
        roi_y0 <= 12'(ROI_Y0);
        roi_y1 <= 12'(ROI_Y1);
      end else if (state == S_REPORT) begin
        roi_x0 <= clamp_edge(lat_x_min, 1'b0, ROI_X0, ROI_X1);
        roi_x1 <= clamp_edge(lat_x_max, 1'b1, ROI_X0, ROI_X1);
        roi_y0 <= clamp_edge(lat_y_min, 1'b0, ROI_Y0, ROI_Y1);
        roi_y1 <= clamp_edge(lat_y_max, 1'b1, ROI_Y0, ROI_Y1);
      end
    end
  end
`else
  logic unused_auto_roi;
  assign unused_auto_roi = ^{det_x_min, det_x_max, det_y_min, det_y_max, 13'(ROI_MARGIN)};
  assign roi_x0 = 12'(ROI_X0);
  assign roi_x1 = 12'(ROI_X1);
  assign roi_y0 = 12'(ROI_Y0);
  assign roi_y1 = 12'(ROI_Y1);
`endif

endmodule

// File: tb/tb_gesture_frame_ctrl.sv
// tb/tb_gesture_frame_ctrl.sv - directed self-checking bench for gesture_frame_ctrl
module tb_gesture_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        per_frame_vsync;
  logic        det_en;
  logic [11:0] det_x_min, det_x_max, det_y_min, det_y_max;
  logic [19:0] det_area, det_ratio;
  logic [11:0] roi_x0, roi_x1, roi_y0, roi_y1;
  logic        det_start;
  logic [1:0]  gesture_code;
  logic        gesture_valid;
  logic        busy;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gesture_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .per_frame_vsync(per_frame_vsync),
    .det_en(det_en), .det_x_min(det_x_min), .det_x_max(det_x_max),
    .det_y_min(det_y_min), .det_y_max(det_y_max), .det_area(det_area),
    .det_ratio(det_ratio), .roi_x0(roi_x0), .roi_x1(roi_x1), .roi_y0(roi_y0),
    .roi_y1(roi_y1), .det_start(det_start), .gesture_code(gesture_code),
    .gesture_valid(gesture_valid), .busy(busy), .timeout_err(timeout_err)
  );

  // One frame: vsync pulse (det_en drops with it), then a detector result.
  // valid_at is the negedge index (1-based) after det_en rises where gesture_valid was seen.
  task automatic run_frame(input logic [19:0] area, input logic [19:0] ratio,
                           input logic [11:0] x0, input logic [11:0] x1,
                           input logic [11:0] y0, input logic [11:0] y1,
                           output int n_valid, output int valid_at, output int n_start);
    n_valid = 0; valid_at = 0; n_start = 0;
    @(negedge clk);
    per_frame_vsync = 1'b1;
    det_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 1) per_frame_vsync = 1'b0;
      if (det_start) n_start++;
      if (gesture_valid) n_valid++;
    end
    det_area = area; det_ratio = ratio;
    det_x_min = x0; det_x_max = x1; det_y_min = y0; det_y_max = y1;
    det_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (det_start) n_start++;
      if (gesture_valid) begin
        n_valid++;
        if (valid_at == 0) valid_at = i;
      end
    end
  endtask

  task automatic run_vsync_only(output int n_start, output int n_valid);
    n_start = 0; n_valid = 0;
    @(negedge clk);
    per_frame_vsync = 1'b1;
    det_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 1) per_frame_vsync = 1'b0;
      if (det_start) n_start++;
      if (gesture_valid) n_valid++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b0; per_frame_vsync = 1'b0; det_en = 1'b0;
    det_x_min = 0; det_x_max = 0; det_y_min = 0; det_y_max = 0;
    det_area = 0; det_ratio = 0;
    repeat (3) @(negedge clk);
    tests++; if (roi_x0 !== 12'd150) begin fails++; $display("FAIL reset_roi_x0: got %0d expected 150", roi_x0); end
    tests++; if (roi_x1 !== 12'd450) begin fails++; $display("FAIL reset_roi_x1: got %0d expected 450", roi_x1); end
    tests++; if (roi_y0 !== 12'd50) begin fails++; $display("FAIL reset_roi_y0: got %0d expected 50", roi_y0); end
    tests++; if (roi_y1 !== 12'd350) begin fails++; $display("FAIL reset_roi_y1: got %0d expected 350", roi_y1); end
    tests++; if (gesture_code !== 2'd0) begin fails++; $display("FAIL reset_code: got %0d expected 0", gesture_code); end
    tests++; if (gesture_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", gesture_valid); end
    tests++; if (det_start !== 1'b0) begin fails++; $display("FAIL reset_det_start: got %b expected 0", det_start); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b expected 0", timeout_err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_enable_vsync;
    int ns, nv;
    enable = 1'b1;
    @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL enable_busy: got %b expected 1", busy); end
    for (int k = 0; k < 2; k++) begin
      run_vsync_only(ns, nv);
      tests++; if (ns !== 1) begin fails++; $display("FAIL vsync_det_start_%0d: got %0d pulses expected 1", k, ns); end
      tests++; if (nv !== 0) begin fails++; $display("FAIL vsync_no_valid_%0d: got %0d pulses expected 0", k, nv); end
    end
    tests++; if (roi_x1 !== 12'd450 || roi_y1 !== 12'd350) begin fails++; $display("FAIL run_roi: got %0d/%0d expected 450/350", roi_x1, roi_y1); end
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL early_timeout: got %b expected 0", timeout_err); end
  endtask

  task automatic test_open_stable;
    int nv, at, ns;
    for (int f = 1; f <= 4; f++) begin
      run_frame(20'd5000, 20'd50, 0, 0, 0, 0, nv, at, ns);
      tests++; if (ns !== 1) begin fails++; $display("FAIL open_det_start_f%0d: got %0d expected 1", f, ns); end
      if (f == 3) begin
        tests++; if (nv !== 1) begin fails++; $display("FAIL open_pulse_f3: got %0d pulses expected 1", nv); end
        tests++; if (at !== 4) begin fails++; $display("FAIL open_latency: got %0d expected 4", at); end
        tests++; if (gesture_code !== 2'd3) begin fails++; $display("FAIL open_code: got %0d expected 3", gesture_code); end
      end else begin
        tests++; if (nv !== 0) begin fails++; $display("FAIL open_silent_f%0d: got %0d pulses expected 0", f, nv); end
      end
    end
  endtask

  task automatic test_timeout;
    int ns, nv;
    for (int k = 0; k < 5; k++) run_vsync_only(ns, nv);
    tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL timeout_set: got %b expected 1", timeout_err); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL timeout_busy: got %b expected 1", busy); end
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL timeout_clear: got %b expected 0", timeout_err); end
    tests++; if (gesture_code !== 2'd3) begin fails++; $display("FAIL timeout_code_hold: got %0d expected 3", gesture_code); end
  endtask

  task automatic test_fist_alternate;
    logic [19:0] ratios [6];
    int nv, at, ns;
    ratios = '{20'd10, 20'd10, 20'd30, 20'd10, 20'd10, 20'd10};
    for (int f = 0; f < 6; f++) begin
      run_frame(20'd5000, ratios[f], 0, 0, 0, 0, nv, at, ns);
      if (f == 5) begin
        tests++; if (nv !== 1) begin fails++; $display("FAIL fist_pulse: got %0d pulses expected 1", nv); end
        tests++; if (gesture_code !== 2'd1) begin fails++; $display("FAIL fist_code: got %0d expected 1", gesture_code); end
      end else begin
        tests++; if (nv !== 0) begin fails++; $display("FAIL fist_silent_f%0d: got %0d pulses expected 0", f, nv); end
      end
    end
  endtask

  task automatic test_enable_clears;
    int nv, at, ns;
    for (int f = 0; f < 2; f++) run_frame(20'd5000, 20'd30, 0, 0, 0, 0, nv, at, ns);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    for (int f = 0; f < 3; f++) begin
      run_frame(20'd5000, 20'd30, 0, 0, 0, 0, nv, at, ns);
      if (f == 2) begin
        tests++; if (nv !== 1 || gesture_code !== 2'd2) begin fails++; $display("FAIL point_after_enable: got %0d pulses code %0d expected 1 pulse code 2", nv, gesture_code); end
      end else begin
        tests++; if (nv !== 0) begin fails++; $display("FAIL point_silent_f%0d: got %0d pulses expected 0", f, nv); end
      end
    end
  endtask

  task automatic test_none;
    int nv, at, ns;
    for (int f = 0; f < 3; f++) begin
      run_frame(20'd300, 20'd10, 0, 0, 0, 0, nv, at, ns);
      if (f == 2) begin
        tests++; if (nv !== 1 || at !== 4) begin fails++; $display("FAIL none_pulse: got %0d pulses at %0d expected 1 at 4", nv, at); end
        tests++; if (gesture_code !== 2'd0) begin fails++; $display("FAIL none_code: got %0d expected 0", gesture_code); end
      end else begin
        tests++; if (nv !== 0) begin fails++; $display("FAIL none_silent_f%0d: got %0d pulses expected 0", f, nv); end
      end
    end
  endtask

`ifdef GESTURE_AUTO_ROI_EN
  task automatic test_auto_roi;
    int nv, at, ns;
    run_frame(20'd5000, 20'd50, 12'd160, 12'd200, 12'd60, 12'd100, nv, at, ns);
    tests++; if (roi_x0 !== 12'd150 || roi_x1 !== 12'd216 || roi_y0 !== 12'd50 || roi_y1 !== 12'd116) begin
      fails++; $display("FAIL auto_roi: got %0d/%0d/%0d/%0d expected 150/216/50/116", roi_x0, roi_x1, roi_y0, roi_y1); end
    run_frame(20'd300, 20'd50, 12'd160, 12'd200, 12'd60, 12'd100, nv, at, ns);
    tests++; if (roi_x0 !== 12'd150 || roi_x1 !== 12'd450 || roi_y0 !== 12'd50 || roi_y1 !== 12'd350) begin
      fails++; $display("FAIL auto_roi_restore: got %0d/%0d/%0d/%0d expected 150/450/50/350", roi_x0, roi_x1, roi_y0, roi_y1); end
  endtask
`endif

  initial begin
    test_reset;
    test_enable_vsync;
    test_open_stable;
    test_timeout;
    test_fist_alternate;
    test_enable_clears;
    test_none;
`ifdef GESTURE_AUTO_ROI_EN
    test_auto_roi;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
